adj_fm_wm_result_buffer: RTL

Multi-row result store for the final ADJ x FM x WM product in the GCN datapath.
- Receives one completed output row per write handshake from the dot-product stage.
- Stores rows sequentially in a register array of NUM_ROWS entries.
- Raises done once the full output matrix has been written.
- Provides a registered random-access read port for the output/readback stage.

---
 rtl/adj_fm_wm_result_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/adj_fm_wm_result_buffer.sv
// Result store for the final ADJ x FM x WM product: rows are filled sequentially and read back at random.
// Optional build macro ADJ_FM_WM_RELU_EN rectifies each element before it is stored.
module adj_fm_wm_result_buffer #(
  parameter  int DOT_PROD_COLS      = 3,
  parameter  int ADJ_DOT_PROD_WIDTH = 16,
  parameter  int NUM_ROWS           = 6,
  localparam int ADDR_W             = $clog2(NUM_ROWS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADJ_DOT_PROD_WIDTH-1:0] wr_data [DOT_PROD_COLS],
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [ADJ_DOT_PROD_WIDTH-1:0] rd_data [DOT_PROD_COLS],
  output logic                          rd_valid,
  output logic [ADDR_W:0]               row_count,
  output logic                          done
);

  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_ROWS - 1);
  localparam logic [ADDR_W:0]   NUM_ROWS_W = (ADDR_W + 1)'(NUM_ROWS);

  typedef enum logic {
    S_FILL = 1'b0,
    S_DONE = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [ADDR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]                 row_count_q, row_count_d;
  logic                            wr_en;

  logic signed [ADJ_DOT_PROD_WIDTH-1:0] mem_q     [NUM_ROWS][DOT_PROD_COLS];
  logic signed [ADJ_DOT_PROD_WIDTH-1:0] wr_row    [DOT_PROD_COLS];
  logic signed [ADJ_DOT_PROD_WIDTH-1:0] rd_data_q [DOT_PROD_COLS];
  logic                                 rd_valid_q;
  logic                                 rd_in_range;

`ifdef ADJ_FM_WM_RELU_EN
  function automatic logic signed [ADJ_DOT_PROD_WIDTH-1:0] relu(
    input logic signed [ADJ_DOT_PROD_WIDTH-1:0] elem
  );
    return elem[ADJ_DOT_PROD_WIDTH-1] ? '0 : elem;
  endfunction

  always_comb begin
    for (int k = 0; k < DOT_PROD_COLS; k++) begin
      wr_row[k] = relu(wr_data[k]);
    end
  end
`else
  always_comb begin
    for (int k = 0; k < DOT_PROD_COLS; k++) begin
      wr_row[k] = wr_data[k];
    end
  end
`endif

  // Fill control: clear overrides any handshake in the same cycle
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    row_count_d = row_count_q;
    wr_ready    = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      S_FILL: begin
        wr_ready = 1'b1;
        if (wr_valid && !clear) begin
          wr_en       = 1'b1;
          row_count_d = row_count_q + (ADDR_W + 1)'(1);
          if (wr_ptr_q == LAST_PTR) begin
            state_d = S_DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        wr_ready = 1'b0;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
    if (clear) begin
      state_d     = S_FILL;
      wr_ptr_d    = '0;
      row_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      row_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      row_count_q <= row_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int k = 0; k < DOT_PROD_COLS; k++) begin
          mem_q[r][k] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int k = 0; k < DOT_PROD_COLS; k++) begin
        mem_q[wr_ptr_q][k] <= wr_row[k];
      end
    end
  end

  // Read stage: samples the pre-write contents, so a same-address write is seen only on a later read
  assign rd_in_range = ({1'b0, rd_addr} < NUM_ROWS_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      for (int k = 0; k < DOT_PROD_COLS; k++) begin
        rd_data_q[k] <= '0;
      end
    end else if (rd_en) begin
      rd_valid_q <= 1'b1;
      for (int k = 0; k < DOT_PROD_COLS; k++) begin
        rd_data_q[k] <= rd_in_range ? mem_q[rd_addr][k] : '0;
      end
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < DOT_PROD_COLS; k++) begin
      rd_data[k] = rd_data_q[k];
    end
  end

  assign rd_valid  = rd_valid_q;
  assign row_count = row_count_q;
  assign done      = (state_q == S_DONE);

endmodule
